dpram_be: RTL and testbench
===========================

Name: dpram_be

Overview:
- Single-clock simple dual-port RAM with one write port and one read port. It is the parametrised successor to the team's plain dual-port RAM primitive.
- Adds per-byte write enables, a read enable with a valid strobe, selectable read latency (1 or 2), selectable read-during-write behaviour, and an optional post-reset memory-clear sweep.
- Used as the backing store for FIFOs, line buffers and register files inside a single clock domain.

Parameters:
- ADDR_WIDTH, 8, address bits; depth = 2**ADDR_WIDTH words.
- DATA_WIDTH, 32, word width; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8, bits per write-enable lane; NUM_BYTES = DATA_WIDTH/BYTE_WIDTH.
- READ_LATENCY, 1, cycles from accepted read to rd_valid; legal values 1 or 2.
- RDW_MODE, 0, same-address read-during-write result: 0 = old data, 1 = new (merged) data.
- INIT_CLEAR, 1, 1 = zero every word after reset; 0 = no sweep, contents undefined at power-up.

Ports:
- clk  in  1  sole clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_en  in  1  write request.
- wr_be  in  NUM_BYTES  byte-lane write enables; bit i covers wr_data[i*BYTE_WIDTH +: BYTE_WIDTH].
- wr_data  in  DATA_WIDTH  write data.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_en  in  1  read request.
- rd_data  out  DATA_WIDTH  read data.
- rd_valid  out  1  one-cycle strobe marking rd_data as the result of an accepted read.
- init_busy  out  1  high while the clear sweep runs; the RAM ignores requests while high.

Behaviour:
- Reset (rst=1 at an edge): rd_data=0, rd_valid=0, pipeline valid bits cleared. init_busy=1 if INIT_CLEAR=1, else 0. Clear counter set to 0. Memory contents are untouched by rst itself.
- Clear FSM (INIT_CLEAR=1), states CLEAR and READY:
  - CLEAR is entered on rst. Each cycle it writes all-zeros to address cnt, then increments cnt.
  - When cnt = 2**ADDR_WIDTH-1 has been written, the FSM moves to READY and init_busy falls at that same edge.
  - A full sweep therefore takes exactly 2**ADDR_WIDTH cycles after rst deasserts.
  - rst during CLEAR restarts the sweep at address 0. rst in READY re-enters CLEAR.
- While init_busy=1: wr_en and rd_en are ignored (no write, rd_valid stays 0). Callers must hold requests until init_busy=0.
- Write: at an edge with wr_en=1 and init_busy=0, for each i with wr_be[i]=1, byte i of mem[wr_addr] takes the wr_data byte. Other bytes are unchanged. wr_be=0 is a legal no-op.
- Read, accepted at an edge where rd_en=1 and init_busy=0:
  - READ_LATENCY=1: rd_data and rd_valid=1 appear after that same edge.
  - READ_LATENCY=2: rd_data is registered once more; rd_valid=1 one edge later.
  - Back-to-back reads give one result per cycle, in order.
- rd_valid is high for exactly one cycle per accepted read.
- rd_data holds its last value when no read completes; it is never forced to 0 except by rst.
- Read-during-write: same edge, rd_en & wr_en, rd_addr == wr_addr.
  - RDW_MODE=0: read returns the pre-write word.
  - RDW_MODE=1: read returns the merged word, taking wr_data bytes where wr_be=1 and old bytes elsewhere.
  - Different addresses: no interaction.
  - With READ_LATENCY=2, a write at the following edge does not alter an already-captured read.
- Address wrap: addresses are ADDR_WIDTH bits; there is no out-of-range case.
- INIT_CLEAR=0: no FSM; init_busy is constant 0; requests are accepted from the first edge after rst.
- Memory array must infer block RAM: no reset on the array, and the clear is done only through the write port.

Test Plan:
- Clear sweep: ADDR_WIDTH=4, INIT_CLEAR=1; pulse rst for 1 cycle -> init_busy high for exactly 16 cycles. Then reads of all 16 addresses -> 0x00000000 with rd_valid pulses. A write attempted during busy to addr 3 is lost (reads 0).
- Byte enables: write 0xAABBCCDD to addr 5 with be=4'hF, then 0x11223344 with be=4'b0101; read addr 5 -> 0xAA22CC44.
- Latency: READ_LATENCY=1, rd_en at edge N -> rd_valid at N only. READ_LATENCY=2 -> rd_valid at N+1 only. 8 back-to-back reads of addrs 0..7 holding value=addr*3 -> 8 consecutive valid cycles, data 0,3,...,21 in order.
- RDW: mem[9]=0x12345678; same edge write 0xFFFFFFFF be=4'b0011 and read addr 9 -> RDW_MODE=0 returns 0x12345678, RDW_MODE=1 returns 0x1234FFFF; a subsequent read returns 0x1234FFFF in both modes.
- Reset mid-sweep: ADDR_WIDTH=4, assert rst at sweep cycle 7 -> init_busy stays high, sweep restarts from address 0, total busy = 16 cycles after the second rst deasserts. rd_data=0 and rd_valid=0 right after the reset edge.
- Hold/idle: after a read returning 0xDEADBEEF, idle 5 cycles -> rd_data stays 0xDEADBEEF, rd_valid stays 0.

Source files
------------

// File: rtl/dpram_be.sv
// Single-clock simple dual-port RAM with byte-lane write enables, 1- or 2-cycle
// read latency, selectable read-during-write result and optional zeroing sweep.
module dpram_be #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int BYTE_WIDTH   = 8,
    parameter int READ_LATENCY = 1,
    parameter int RDW_MODE     = 0,
    parameter int INIT_CLEAR   = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [ADDR_WIDTH-1:0]              wr_addr,
    input  logic                               wr_en,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   wr_be,
    input  logic [DATA_WIDTH-1:0]              wr_data,
    input  logic [ADDR_WIDTH-1:0]              rd_addr,
    input  logic                               rd_en,
    output logic [DATA_WIDTH-1:0]              rd_data,
    output logic                               rd_valid,
    output logic                               init_busy
);

    localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH     = 2 ** ADDR_WIDTH;

    typedef enum logic {CLEAR, READY} state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  busy;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  wr_act;
    logic                  rd_acc;
    logic                  we_eff;
    logic [ADDR_WIDTH-1:0] wa_eff;
    logic [DATA_WIDTH-1:0] wd_eff;
    logic [NUM_BYTES-1:0]  be_eff;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] rd_data_p1;
    logic                  vld_p1;

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [NUM_BYTES-1:0]  be
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_w;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (be[i]) res[i*BYTE_WIDTH +: BYTE_WIDTH] = new_w[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
        return res;
    endfunction

    generate
        if (INIT_CLEAR != 0) begin : g_clear
            state_t                state, state_nxt;
            logic [ADDR_WIDTH-1:0] cnt;

            always_ff @(posedge clk) begin
                if (rst) begin
                    state <= CLEAR;
                    cnt   <= '0;
                end else begin
                    state <= state_nxt;
                    if (state == CLEAR) cnt <= cnt + 1'b1;
                end
            end

            always_comb begin
                state_nxt = state;
                case (state)
                    CLEAR:   if (cnt == '1) state_nxt = READY;
                    READY:   state_nxt = READY;
                    default: state_nxt = CLEAR;
                endcase
            end

            assign busy     = (state == CLEAR);
            assign clr_addr = cnt;
        end else begin : g_noclear
            assign busy     = 1'b0;
            assign clr_addr = '0;
        end
    endgenerate

    assign init_busy = busy;

    // The sweep borrows the single write port so the array keeps a plain RAM shape.
    assign wr_act = ~rst & ~busy & wr_en;
    assign rd_acc = ~rst & ~busy & rd_en;
    assign we_eff = ~rst & (busy | wr_en);
    assign wa_eff = busy ? clr_addr : wr_addr;
    assign wd_eff = busy ? '0 : wr_data;
    assign be_eff = busy ? '1 : wr_be;

    always_ff @(posedge clk) begin
        if (we_eff) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (be_eff[i]) mem[wa_eff][i*BYTE_WIDTH +: BYTE_WIDTH] <= wd_eff[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    always_comb begin
        rd_word = mem[rd_addr];
        if (RDW_MODE != 0 && wr_act && rd_addr == wr_addr) begin
            rd_word = merge_bytes(rd_word, wr_data, wr_be);
        end
    end

    // Stage p1: array read captured
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            rd_data_p1 <= '0;
        end else begin
            vld_p1 <= rd_acc;
            if (rd_acc) rd_data_p1 <= rd_word;
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] rd_data_p2;
            logic                  vld_p2;

            // Stage p2: output register
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_p2     <= 1'b0;
                    rd_data_p2 <= '0;
                end else begin
                    vld_p2 <= vld_p1;
                    if (vld_p1) rd_data_p2 <= rd_data_p1;
                end
            end

            assign rd_data  = rd_data_p2;
            assign rd_valid = vld_p2;
        end else begin : g_lat1
            assign rd_data  = rd_data_p1;
            assign rd_valid = vld_p1;
        end
    endgenerate

endmodule

// File: tb/tb_dpram_be.sv
// Scoreboard bench for dpram_be: one instance with 1-cycle latency/old-data RDW,
// one with 2-cycle latency/new-data RDW, both driven by the same stimulus.
module tb_dpram_be;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  wr_addr = '0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_be = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  rd_addr = '0;
    logic        rd_en = 1'b0;

    logic [31:0] rd_data_a, rd_data_b;
    logic        rd_valid_a, rd_valid_b;
    logic        busy_a, busy_b;

    typedef struct {
        logic [31:0] d;
        int          c;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [31:0] mem_m [16];
    int          busy_left = 0;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dpram_be #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8),
               .READ_LATENCY(1), .RDW_MODE(0), .INIT_CLEAR(1)) u_a (
        .clk(clk), .rst(rst), .wr_addr(wr_addr), .wr_en(wr_en), .wr_be(wr_be),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_en(rd_en),
        .rd_data(rd_data_a), .rd_valid(rd_valid_a), .init_busy(busy_a));

    dpram_be #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8),
               .READ_LATENCY(2), .RDW_MODE(1), .INIT_CLEAR(1)) u_b (
        .clk(clk), .rst(rst), .wr_addr(wr_addr), .wr_en(wr_en), .wr_be(wr_be),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_en(rd_en),
        .rd_data(rd_data_b), .rd_valid(rd_valid_b), .init_busy(busy_b));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = n[i*8 +: 8];
        return r;
    endfunction

    // Read-result monitors: data and arrival cycle must match the scoreboard head.
    always @(negedge clk) begin
        if (rd_valid_a === 1'b1) begin
            if (qa.size() == 0) chk("a_spurious_valid", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = qa.pop_front();
                chk("a_data", rd_data_a, e.d);
                chk("a_cycle", cyc, e.c);
            end
        end else if (qa.size() != 0 && qa[0].c <= cyc) begin
            chk("a_missing_valid", 32'd0, 32'd1);
            void'(qa.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rd_valid_b === 1'b1) begin
            if (qb.size() == 0) chk("b_spurious_valid", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = qb.pop_front();
                chk("b_data", rd_data_b, e.d);
                chk("b_cycle", cyc, e.c);
            end
        end else if (qb.size() != 0 && qb[0].c <= cyc) begin
            chk("b_missing_valid", 32'd0, 32'd1);
            void'(qb.pop_front());
        end
    end

    // Called at a negedge; returns at the following negedge.
    task automatic step(input bit we, input logic [3:0] wa, input logic [3:0] be,
                        input logic [31:0] wd, input bit re, input logic [3:0] ra,
                        input bit fixed, input logic [31:0] fa, input logic [31:0] fb);
        logic [31:0] ea, eb;
        chk("busy_a", 32'(busy_a), 32'(busy_left > 0));
        chk("busy_b", 32'(busy_b), 32'(busy_left > 0));
        wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd;
        rd_en = re; rd_addr = ra;
        if (re && busy_left == 0) begin
            ea = mem_m[ra];
            eb = (we && wa == ra) ? merge(mem_m[ra], wd, be) : mem_m[ra];
            if (fixed) begin ea = fa; eb = fb; end
            qa.push_back('{ea, cyc + 1});
            qb.push_back('{eb, cyc + 2});
        end
        if (we && busy_left == 0) mem_m[wa] = merge(mem_m[wa], wd, be);
        @(posedge clk);
        if (busy_left > 0) busy_left--;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
        step(1, a, be, d, 0, 0, 0, 0, 0);
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        wr_en = 1'b0; rd_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_rd_data_a", rd_data_a, 32'h0);
        chk("rst_rd_data_b", rd_data_b, 32'h0);
        chk("rst_rd_valid_a", 32'(rd_valid_a), 32'h0);
        chk("rst_rd_valid_b", 32'(rd_valid_b), 32'h0);
        busy_left = 16;
        for (int i = 0; i < 16; i++) mem_m[i] = 32'h0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_pulse();

        // Requests during the sweep are dropped; the write to 3 must be lost.
        step(1, 3, 4'hF, 32'hFFFF_FFFF, 1, 3, 0, 0, 0);
        idle(15);

        for (int a = 0; a < 16; a++) step(0, 0, 0, 0, 1, 4'(a), 1, 32'h0, 32'h0);
        idle(3);

        wr(5, 4'hF, 32'hAABB_CCDD);
        wr(5, 4'b0101, 32'h1122_3344);
        step(0, 0, 0, 0, 1, 5, 1, 32'hAA22_CC44, 32'hAA22_CC44);
        idle(3);

        for (int a = 0; a < 8; a++) wr(4'(a), 4'hF, 32'(a * 3));
        for (int a = 0; a < 8; a++) step(0, 0, 0, 0, 1, 4'(a), 1, 32'(a * 3), 32'(a * 3));
        idle(3);

        wr(9, 4'hF, 32'h1234_5678);
        step(1, 9, 4'b0011, 32'hFFFF_FFFF, 1, 9, 1, 32'h1234_5678, 32'h1234_FFFF);
        step(0, 0, 0, 0, 1, 9, 1, 32'h1234_FFFF, 32'h1234_FFFF);
        idle(3);

        wr(0, 4'h0, 32'hFFFF_FFFF);
        step(0, 0, 0, 0, 1, 0, 1, 32'h0, 32'h0);

        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 4'($urandom),
                 $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 0, 0, 0);
        end
        idle(3);

        wr(2, 4'hF, 32'hDEAD_BEEF);
        step(0, 0, 0, 0, 1, 2, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        idle(2);
        for (int i = 0; i < 5; i++) begin
            chk("hold_data_a", rd_data_a, 32'hDEAD_BEEF);
            chk("hold_data_b", rd_data_b, 32'hDEAD_BEEF);
            chk("hold_valid_a", 32'(rd_valid_a), 32'h0);
            chk("hold_valid_b", 32'(rd_valid_b), 32'h0);
            idle(1);
        end

        rst_pulse();
        idle(7);
        rst_pulse();
        idle(16);
        step(0, 0, 0, 0, 1, 2, 1, 32'h0, 32'h0);
        step(0, 0, 0, 0, 1, 9, 1, 32'h0, 32'h0);
        idle(4);

        chk("a_queue_drained", 32'(qa.size()), 32'h0);
        chk("b_queue_drained", 32'(qb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
